// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and constants for the I2S receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Receiver alignment state: hunting for a WS edge, or frame-aligned.
  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } i2s_rx_state_e;

  // Audio channel a completed word belongs to.
  typedef enum logic [0:0] {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

  // Width of the per-slot bit counter (saturates at 63).
  localparam int SLOT_CNT_W = 6;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-stage flop synchroniser for a single asynchronous bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Next value of the chain: new sample enters at bit 0.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser flops, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_deser
//  Description : I2S receive deserialiser. Detects SCK rises in the system
//                clock domain, shifts in MSB-first words and presents each
//                left/right pair on a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int   DATA_W      = 24,
  parameter logic WS_POL      = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              locked_o,
  output logic              overrun_o,
  output logic              frame_err_o
);

  localparam logic [SLOT_CNT_W-1:0] C_DATA_W = SLOT_CNT_W'(DATA_W);
  localparam logic [SLOT_CNT_W-1:0] C_LAST   = SLOT_CNT_W'(DATA_W - 1);

  logic                  sd_s;
  logic                  rise;
  logic                  chg;
  logic                  shift_en;
  logic                  word_ok;
  i2s_chan_e             word_ch;
  logic [DATA_W-1:0]     shift_in;

  i2s_rx_state_e         state_q,     state_d;
  logic                  sck_prev_q,  sck_prev_d;
  logic                  ws_last_q,   ws_last_d;
  logic [SLOT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0]     shift_q,     shift_d;
  logic [DATA_W-1:0]     left_hold_q, left_hold_d;
  logic                  left_pend_q, left_pend_d;
  logic [DATA_W-1:0]     left_q,      left_d;
  logic [DATA_W-1:0]     right_q,     right_d;
  logic                  valid_q,     valid_d;
  logic                  overrun_q,   overrun_d;
  logic                  frame_err_q, frame_err_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sd_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sd_i),
    .q_o   (sd_s)
  );

  // A one-bit word has no history to keep; wider words shift left.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shift_in = sd_s;
    end else begin : g_shift_multi
      assign shift_in = {shift_q[DATA_W-2:0], sd_s};
    end
  endgenerate

  // Edge detection and word-boundary decode for the current cycle.
  always_comb begin
    rise     = sck_i & ~sck_prev_q;
    chg      = rise & (ws_i != ws_last_q);
    shift_en = (state_q == RUN) & rise & (bit_cnt_q < C_DATA_W);
    word_ok  = (bit_cnt_q >= C_LAST);
    word_ch  = (ws_last_q == WS_POL) ? CH_LEFT : CH_RIGHT;
    // Bits past DATA_W in a long slot are dropped; the word keeps its MSBs.
    shift_d  = shift_en ? shift_in : shift_q;
  end

  // Alignment FSM, word assembly and output handshake.
  always_comb begin
    state_d     = state_q;
    sck_prev_d  = sck_i;
    ws_last_d   = ws_last_q;
    bit_cnt_d   = bit_cnt_q;
    left_hold_d = left_hold_q;
    left_pend_d = left_pend_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q & ~ready_i;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    if (rise) begin
      ws_last_d = ws_i;
    end

    if (state_q == SYNC) begin
      // The word in flight at lock time is incomplete and is discarded.
      if (chg) begin
        state_d   = RUN;
        bit_cnt_d = '0;
      end
    end else if (rise) begin
      if (!chg) begin
        if (bit_cnt_q != '1) begin
          bit_cnt_d = bit_cnt_q + SLOT_CNT_W'(1);
        end
      end else begin
        // WS leads data by one SCK, so this rise carried the word's LSB.
        bit_cnt_d = '0;
        if (!word_ok) begin
          frame_err_d = 1'b1;
          left_pend_d = 1'b0;
        end else if (word_ch == CH_LEFT) begin
          left_hold_d = shift_d;
          left_pend_d = 1'b1;
        end else if (left_pend_q) begin
          left_pend_d = 1'b0;
          if (!valid_q || ready_i) begin
            left_d  = left_hold_q;
            right_d = shift_d;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SYNC;
      sck_prev_q  <= 1'b0;
      ws_last_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_pend_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_prev_d;
      ws_last_q   <= ws_last_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_pend_q <= left_pend_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign left_o      = left_q;
  assign right_o     = right_q;
  assign valid_o     = valid_q;
  assign locked_o    = (state_q == RUN);
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx_deser
//  Description : Self-checking bench for i2s_rx_deser (DATA_W 24 and 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_deser;

  localparam logic WS_POL = 1'b0;
  localparam logic WS_L   = WS_POL;
  localparam logic WS_R   = ~WS_POL;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ws = WS_L, sd = 1'b0, ready = 1'b1;
  always #5 clk = ~clk;

  logic [23:0] w_l24, w_r24;
  logic [31:0] w_l32, w_r32;
  logic        w_v24, w_lk24, w_ov24, w_fe24;
  logic        w_v32, w_lk32, w_ov32, w_fe32;

  i2s_rx_deser #(.DATA_W(24), .WS_POL(WS_POL), .SYNC_STAGES(2)) u_dut24 (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .left_o(w_l24), .right_o(w_r24), .valid_o(w_v24), .ready_i(ready),
    .locked_o(w_lk24), .overrun_o(w_ov24), .frame_err_o(w_fe24));

  i2s_rx_deser #(.DATA_W(32), .WS_POL(WS_POL), .SYNC_STAGES(3)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .left_o(w_l32), .right_o(w_r32), .valid_o(w_v32), .ready_i(ready),
    .locked_o(w_lk32), .overrun_o(w_ov32), .frame_err_o(w_fe32));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit rnd_ready = 1'b0;

  // ---------------- behavioural model (word level) ----------------
  int        W [2] = '{24, 32};
  bit        m_locked, m_wslast;
  bit        q_bits[$];              // bits seen since the last WS change
  bit [31:0] m_hold [2];
  bit        m_pend [2];
  bit [31:0] e_left [2], e_right [2];
  bit        e_valid [2], e_ovr [2], e_ferr [2];
  bit        rise_ev = 1'b0, rise_ws = 1'b0, rise_sd = 1'b0;
  bit        nv [2];
  bit [31:0] wv;

  function automatic void model_reset();
    m_locked = 1'b0;
    m_wslast = 1'b0;
    q_bits.delete();
    for (int d = 0; d < 2; d++) begin
      m_hold[d] = '0; m_pend[d] = 1'b0; e_left[d] = '0; e_right[d] = '0;
      e_valid[d] = 1'b0; e_ovr[d] = 1'b0; e_ferr[d] = 1'b0;
    end
  endfunction

  // A word ends on the SCK rise where WS differs from the previous rise;
  // it consists of every bit since the previous such rise, this one included.
  always @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        nv[d] = e_valid[d] && !ready;
        e_ovr[d] = 1'b0;
        e_ferr[d] = 1'b0;
      end
      if (rise_ev) begin
        q_bits.push_back(rise_sd);
        if (rise_ws != m_wslast) begin
          if (m_locked) begin
            for (int d = 0; d < 2; d++) begin
              if (q_bits.size() < W[d]) begin
                e_ferr[d] = 1'b1;
                m_pend[d] = 1'b0;
              end else begin
                wv = '0;
                for (int k = 0; k < W[d]; k++) wv = (wv << 1) | 32'(q_bits[k]);
                if (m_wslast == WS_L) begin
                  m_hold[d] = wv;
                  m_pend[d] = 1'b1;
                end else if (m_pend[d]) begin
                  m_pend[d] = 1'b0;
                  if (!e_valid[d] || ready) begin
                    e_left[d] = m_hold[d]; e_right[d] = wv; nv[d] = 1'b1;
                  end else begin
                    e_ovr[d] = 1'b1;
                  end
                end
              end
            end
          end else begin
            m_locked = 1'b1;
          end
          q_bits.delete();
        end
        m_wslast = rise_ws;
      end
      for (int d = 0; d < 2; d++) e_valid[d] = nv[d];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cmp(input int d, input logic [31:0] l, input logic [31:0] r,
                     input logic v, input logic lk, input logic ov, input logic fe);
    n_checks++;
    if (l === e_left[d] && r === e_right[d] && v === e_valid[d] && lk === m_locked &&
        ov === e_ovr[d] && fe === e_ferr[d]) begin
      n_pass++;
    end else begin
      $display("FAIL cycle_cmp dut%0d t=%0t: got L=%h R=%h v=%b lk=%b ov=%b fe=%b, expected L=%h R=%h v=%b lk=%b ov=%b fe=%b",
               W[d], $time, l, r, v, lk, ov, fe,
               e_left[d], e_right[d], e_valid[d], m_locked, e_ovr[d], e_ferr[d]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, {8'h00, w_l24}, {8'h00, w_r24}, w_v24, w_lk24, w_ov24, w_fe24);
      cmp(1, w_l32, w_r32, w_v32, w_lk32, w_ov32, w_fe32);
    end
  end

  // Event counters over DUT outputs, used by the hand-computed checks.
  int        acc24 = 0, ovr24 = 0, fe24 = 0;
  logic [23:0] last_l24 = '0, last_r24 = '0;
  logic [31:0] last_l32 = '0, last_r32 = '0;
  always @(posedge clk) begin
    if (!rst) begin
      if (w_v24 && ready) begin acc24++; last_l24 = w_l24; last_r24 = w_r24; end
      if (w_ov24) ovr24++;
      if (w_fe24) fe24++;
      if (w_v32 && ready) begin last_l32 = w_l32; last_r32 = w_r32; end
    end
  end

  // ---------------- stimulus ----------------
  // One SCK period of 8 clk: data and WS change with SCK falling.
  task automatic sck_period(input bit w, input bit b, input bit do_rst, input bit rdy_rise);
    @(negedge clk);
    sck = 1'b0; ws = w; sd = b;
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
    if (do_rst) begin
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_left",  64'(w_l24), 64'h0);
      chk("async_rst_right", 64'(w_r24), 64'h0);
      chk("async_rst_valid", 64'(w_v24), 64'h0);
      chk("async_rst_locked", 64'(w_lk24), 64'h0);
      #1 rst = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
    sck = 1'b1; rise_ev = 1'b1; rise_ws = w; rise_sd = b;
    if (rdy_rise) ready = 1'b1;
    @(negedge clk);
    rise_ev = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  // WS moves to next_w one SCK before the next word's MSB (during this LSB).
  task automatic send_word(input bit w, input logic [63:0] val, input int n, input bit next_w,
                           input int rst_bit, input bit rdy_last);
    for (int i = 0; i < n; i++)
      sck_period((i == n - 1) ? next_w : w, val[n - 1 - i], i == rst_bit,
                 rdy_last && (i == n - 1));
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_word(WS_L, 64'(l), 32, WS_R, -1, 1'b0);
    send_word(WS_R, 64'(r), 32, WS_L, -1, 1'b0);
  endtask

  int a0, o0, f0;

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    chk("reset_left",   64'(w_l24),  64'h0);
    chk("reset_right",  64'(w_r24),  64'h0);
    chk("reset_valid",  64'(w_v24),  64'h0);
    chk("reset_locked", 64'(w_lk24), 64'h0);
    chk("reset_ovr_fe", 64'({w_ov24, w_fe24}), 64'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Nominal: lock on the first WS edge, first pair discarded (right-only).
    a0 = acc24; o0 = ovr24; f0 = fe24;
    repeat (4) send_frame(32'hA5A5A5 << 8, 32'h5A5A5A << 8);
    chk("nom_locked", 64'(w_lk24), 64'h1);
    chk("nom_pairs",  64'(acc24 - a0), 64'd3);
    chk("nom_left",   64'(last_l24), 64'hA5A5A5);
    chk("nom_right",  64'(last_r24), 64'h5A5A5A);
    chk("nom_left32", 64'(last_l32), 64'hA5A5A500);
    chk("nom_no_ovr", 64'(ovr24 - o0), 64'd0);
    chk("nom_no_fe",  64'(fe24 - f0), 64'd0);

    // Asynchronous reset in the middle of a right word.
    send_word(WS_L, 64'(32'h123456 << 8), 32, WS_R, -1, 1'b0);
    send_word(WS_R, 64'(32'h654321 << 8), 32, WS_L, 10, 1'b0);
    a0 = acc24;
    send_frame(32'h0BCDEF << 8, 32'h0FEDCB << 8);
    chk("rst_pairs_after", 64'(acc24 - a0), 64'd1);
    chk("rst_left_after",  64'(last_l24), 64'h0BCDEF);

    // Backpressure: first pair held, next two dropped.
    ready = 1'b0;
    a0 = acc24; o0 = ovr24;
    for (int k = 1; k <= 3; k++) send_frame(32'(k) << 8, (32'h100000 + 32'(k)) << 8);
    chk("bp_hold_left",  64'(w_l24), 64'h000001);
    chk("bp_hold_right", 64'(w_r24), 64'h100001);
    chk("bp_hold_valid", 64'(w_v24), 64'h1);
    chk("bp_overruns",   64'(ovr24 - o0), 64'd2);
    ready = 1'b1;
    send_frame(32'h4 << 8, 32'h100004 << 8);
    chk("bp_pairs",      64'(acc24 - a0), 64'd2);
    chk("bp_next_left",  64'(last_l24), 64'h000004);
    chk("bp_next_right", 64'(last_r24), 64'h100004);

    // Handshake collision: ready rises in the cycle a new pair completes.
    ready = 1'b0;
    a0 = acc24; o0 = ovr24;
    send_frame(32'h111111 << 8, 32'h222222 << 8);
    send_word(WS_L, 64'(32'h333333 << 8), 32, WS_R, -1, 1'b0);
    send_word(WS_R, 64'(32'h444444 << 8), 32, WS_L, -1, 1'b1);
    chk("col_pairs",  64'(acc24 - a0), 64'd2);
    chk("col_left",   64'(last_l24), 64'h333333);
    chk("col_right",  64'(last_r24), 64'h444444);
    chk("col_no_ovr", 64'(ovr24 - o0), 64'd0);

    // Short word: WS toggles after 16 SCKs.
    a0 = acc24; f0 = fe24;
    send_word(WS_L, 64'hABCD, 16, WS_R, -1, 1'b0);
    send_word(WS_R, 64'(32'h777777 << 8), 32, WS_L, -1, 1'b0);
    send_frame(32'h0CAFE0 << 8, 32'h0BEEF0 << 8);
    chk("short_fe",    64'(fe24 - f0), 64'd1);
    chk("short_pairs", 64'(acc24 - a0), 64'd1);
    chk("short_left",  64'(last_l24), 64'h0CAFE0);

    // Full 32-bit words: LSB is captured on the WS-change rise.
    repeat (2) send_frame(32'h80000001, 32'h80000001);
    chk("w32_left",  64'(last_l32), 64'h80000001);
    chk("w32_right", 64'(last_r32), 64'h80000001);
    chk("w24_trunc", 64'(last_l24), 64'h800000);

    // Randomised lengths, data and ready.
    rnd_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      send_word(WS_L, {32'($urandom), 32'($urandom)}, int'($urandom_range(20, 40)), WS_R, -1, 1'b0);
      send_word(WS_R, {32'($urandom), 32'($urandom)}, int'($urandom_range(20, 40)), WS_L, -1, 1'b0);
    end
    rnd_ready = 1'b0;
    ready = 1'b1;
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
